// File: rtl/melody_pkg.sv
// Shared types, ROM field layout and note/duration helpers for the melody sequencer.
package melody_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_HOLD
    } state_t;

    localparam logic [2:0] NOTE_DO   = 3'd0;
    localparam logic [2:0] NOTE_RE   = 3'd1;
    localparam logic [2:0] NOTE_MI   = 3'd2;
    localparam logic [2:0] NOTE_FA   = 3'd3;
    localparam logic [2:0] NOTE_SOL  = 3'd4;
    localparam logic [2:0] NOTE_LA   = 3'd5;
    localparam logic [2:0] NOTE_SI   = 3'd6;
    localparam logic [2:0] NOTE_REST = 3'd7;

    localparam int NOTE_LSB = 0;
    localparam int NOTE_MSB = 2;
    localparam int DUR_LSB  = 3;
    localparam int DUR_MSB  = 4;
    localparam int END_BIT  = 7;

    localparam logic [7:0] SILENT_STROBE = 8'h80;

    // Duration code 00..11 means 1..4 beats.
    function automatic logic [2:0] dur_beats(input logic [1:0] code);
        return {1'b0, code} + 3'd1;
    endfunction

    function automatic logic [7:0] note_onehot(input logic [2:0] note);
        return 8'b0000_0001 << note;
    endfunction

endpackage

// File: rtl/melody_rom.sv
// Song ROM with registered read; contents come from a packed byte-vector parameter
// (entry i occupies bits [8*i+7 : 8*i]).
module melody_rom #(
    parameter int ADDR_W = 5,
    parameter logic [8*(2**ADDR_W)-1:0] SONG = {(2**ADDR_W){8'h80}}
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    logic [7:0] rom_mem [2**ADDR_W];
    logic [7:0] data_reg;

    generate
        for (genvar gi = 0; gi < 2**ADDR_W; gi++) begin : g_rom
            assign rom_mem[gi] = SONG[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        data_reg <= rom_mem[addr];
    end

    assign data = data_reg;

endmodule

// File: rtl/melody_sequencer.sv
// Plays a ROM song onto the one-hot pianos strobe bus; manual keys override and abort playback.
module melody_sequencer
    import melody_pkg::*;
#(
    parameter logic [31:0] BEAT_CYC = 32'd12_499_999,
    parameter logic        LOOP     = 1'b0,
    parameter int          ADDR_W   = 5,
    parameter logic [8*(2**ADDR_W)-1:0] SONG = {(2**ADDR_W){8'h80}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [7:0]        key_in,
    output logic [7:0]        pianos,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] note_addr
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              past_end_reg, past_end_next;
    logic [31:0]       beat_cnt_reg, beat_cnt_next;
    logic [2:0]        beat_idx_reg, beat_idx_next;
    logic [2:0]        beats_reg, beats_next;
    logic [2:0]        note_reg, note_next;
    logic [7:0]        pianos_reg, pianos_next;
    logic              done_reg, done_next;

    logic [7:0]        rom_data;
    logic              rom_end;
    logic              beat_wrap;
    logic              rsvd_unused;

    melody_rom #(
        .ADDR_W (ADDR_W),
        .SONG   (SONG)
    ) u_rom (
        .clk  (clk),
        .addr (addr_reg),
        .data (rom_data)
    );

    assign rsvd_unused = ^rom_data[6:5];
    // Running off the top of the ROM is treated exactly like an end marker.
    assign rom_end   = rom_data[END_BIT] | past_end_reg;
    assign beat_wrap = (beat_cnt_reg == BEAT_CYC);

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        past_end_next = past_end_reg;
        beat_cnt_next = beat_cnt_reg;
        beat_idx_next = beat_idx_reg;
        beats_next    = beats_reg;
        note_next     = note_reg;
        pianos_next   = 8'h00;
        done_next     = 1'b0;

        if (key_in != 8'h00) begin
            pianos_next = key_in;
            state_next  = ST_IDLE;
        end else if (stop && state_reg != ST_IDLE) begin
            pianos_next = SILENT_STROBE;
            state_next  = ST_IDLE;
        end else if (start) begin
            state_next    = ST_FETCH;
            addr_next     = '0;
            past_end_next = 1'b0;
            beat_cnt_next = '0;
            beat_idx_next = '0;
        end else begin
            case (state_reg)
                ST_FETCH: state_next = ST_DECODE;
                ST_DECODE: begin
                    if (rom_end) begin
                        if (LOOP) begin
                            addr_next     = '0;
                            past_end_next = 1'b0;
                            state_next    = ST_FETCH;
                        end else begin
                            done_next   = 1'b1;
                            pianos_next = SILENT_STROBE;
                            state_next  = ST_IDLE;
                        end
                    end else begin
                        note_next     = rom_data[NOTE_MSB:NOTE_LSB];
                        beats_next    = dur_beats(rom_data[DUR_MSB:DUR_LSB]);
                        pianos_next   = note_onehot(rom_data[NOTE_MSB:NOTE_LSB]);
                        beat_cnt_next = '0;
                        beat_idx_next = '0;
                        state_next    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (beat_wrap) begin
                        beat_cnt_next = '0;
                        if (beat_idx_reg == beats_reg - 3'd1) begin
                            {past_end_next, addr_next} = {1'b0, addr_reg} + 1'b1;
                            state_next = ST_FETCH;
                        end else begin
                            beat_idx_next = beat_idx_reg + 3'd1;
                            // Buzzer only rings two beats per strobe; re-strike for long notes.
                            if (beat_idx_reg == 3'd1 && beats_reg >= 3'd3)
                                pianos_next = note_onehot(note_reg);
                        end
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            past_end_reg <= 1'b0;
            beat_cnt_reg <= '0;
            beat_idx_reg <= '0;
            beats_reg    <= '0;
            note_reg     <= NOTE_REST;
            pianos_reg   <= 8'h00;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            past_end_reg <= past_end_next;
            beat_cnt_reg <= beat_cnt_next;
            beat_idx_reg <= beat_idx_next;
            beats_reg    <= beats_next;
            note_reg     <= note_next;
            pianos_reg   <= pianos_next;
            done_reg     <= done_next;
        end
    end

    assign pianos    = pianos_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign note_addr = addr_reg;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench: one non-looping song {Do/1, Mi/2, end} and one looping song {Sol/4, Re/1, end}.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [7:0] key_in;

    logic [7:0] p0, p1;
    logic       b0, b1, d0, d1;
    logic [4:0] a0, a1;

    int total = 0;
    int bad   = 0;
    int d0_cnt = 0;
    int d1_cnt = 0;
    int strays;

    always #5 clk = ~clk;

    melody_sequencer #(
        .BEAT_CYC (32'd9),
        .LOOP     (1'b0),
        .ADDR_W   (5),
        .SONG     ({{29{8'h80}}, 8'h80, 8'h0A, 8'h00})
    ) dut0 (
        .clk (clk), .rst (rst), .start (start), .stop (stop), .key_in (key_in),
        .pianos (p0), .busy (b0), .done (d0), .note_addr (a0)
    );

    melody_sequencer #(
        .BEAT_CYC (32'd9),
        .LOOP     (1'b1),
        .ADDR_W   (5),
        .SONG     ({{29{8'h80}}, 8'h80, 8'h01, 8'h1C})
    ) dut1 (
        .clk (clk), .rst (rst), .start (start), .stop (stop), .key_in (key_in),
        .pianos (p1), .busy (b1), .done (d1), .note_addr (a1)
    );

    always @(posedge clk) begin
        if (d0) d0_cnt <= d0_cnt + 1;
        if (d1) d1_cnt <= d1_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; key_in = 8'h00;
        adv(3);
        rst = 1'b0;
        check("reset_pianos0", p0, 8'h00);
        check("reset_busy0",   b0, 1'b0);
        check("reset_done0",   d0, 1'b0);
        check("reset_addr0",   a0, 5'd0);
        check("reset_pianos1", p1, 8'h00);
        $display("txn reset: pianos0=%h busy0=%b", p0, b0);

        // Song playback; e counts edges since start was raised.
        start = 1'b1; adv(1); start = 1'b0;              // e=1
        check("fetch_busy0",  b0, 1'b1);
        check("fetch_addr0",  a0, 5'd0);
        check("fetch_quiet0", p0, 8'h00);
        adv(2);                                          // e=3
        check("do_strobe",    p0, 8'h01);
        check("sol_strobe",   p1, 8'h10);
        $display("txn first strobes: p0=%h p1=%h", p0, p1);
        adv(1);                                          // e=4
        check("do_one_cycle", p0, 8'h00);
        adv(9);                                          // e=13
        check("do_next_addr", a0, 5'd1);
        adv(2);                                          // e=15
        check("mi_strobe",    p0, 8'h04);
        $display("txn mi strobe: p0=%h", p0);
        adv(8);                                          // e=23
        check("sol_restrike", p1, 8'h10);
        adv(1);                                          // e=24
        check("sol_restrike_1cyc", p1, 8'h00);
        adv(13);                                         // e=37
        check("end_rest",     p0, 8'h80);
        check("end_done",     d0, 1'b1);
        check("end_busy",     b0, 1'b0);
        $display("txn song end: p0=%h done=%b busy=%b", p0, d0, b0);
        adv(1);                                          // e=38
        check("done_one_cycle", d0, 1'b0);
        check("rest_one_cycle", p0, 8'h00);
        adv(5);                                          // e=43
        check("sol_next_fetch", a1, 5'd1);
        adv(2);                                          // e=45
        check("re_strobe",    p1, 8'h02);
        adv(12);                                         // e=57
        check("loop_addr",    a1, 5'd0);
        check("loop_busy",    b1, 1'b1);
        adv(2);                                          // e=59
        check("loop_restrobe", p1, 8'h10);
        $display("txn loop: addr1=%h p1=%h", a1, p1);

        // Manual key mid-HOLD aborts the looping song.
        adv(5);
        key_in = 8'h02; adv(1); key_in = 8'h00;
        check("key_p1",   p1, 8'h02);
        check("key_busy1", b1, 1'b0);
        check("key_p0",   p0, 8'h02);
        strays = 0;
        for (int i = 0; i < 40; i++) begin
            adv(1);
            if (p1 !== 8'h00) strays++;
        end
        check("key_no_song", strays, 0);
        $display("txn key abort: strays=%0d", strays);

        // Key and start together: key wins, sequencer stays idle.
        key_in = 8'h08; start = 1'b1; adv(1); key_in = 8'h00; start = 1'b0;
        check("keystart_p0",   p0, 8'h08);
        check("keystart_busy0", b0, 1'b0);
        check("keystart_busy1", b1, 1'b0);
        adv(1);
        check("keystart_idle", b0, 1'b0);
        check("keystart_quiet", p0, 8'h00);
        $display("txn key+start: busy0=%b", b0);

        // Stop mid-HOLD.
        start = 1'b1; adv(1); start = 1'b0;
        adv(5);
        stop = 1'b1; adv(1); stop = 1'b0;
        check("stop_p0",   p0, 8'h80);
        check("stop_p1",   p1, 8'h80);
        check("stop_busy0", b0, 1'b0);
        check("stop_nodone", d0, 1'b0);
        adv(1);
        check("stop_once", p0, 8'h00);
        $display("txn stop: busy0=%b", b0);

        // Reset during FETCH.
        start = 1'b1; adv(1); start = 1'b0;
        check("pre_rst_busy", b0, 1'b1);
        rst = 1'b1; adv(1);
        check("rst_p0",   p0, 8'h00);
        check("rst_busy0", b0, 1'b0);
        check("rst_done0", d0, 1'b0);
        check("rst_addr0", a0, 5'd0);
        check("rst_p1",   p1, 8'h00);
        adv(1);
        rst = 1'b0;
        strays = 0;
        for (int i = 0; i < 10; i++) begin
            adv(1);
            if ((p0 | p1) !== 8'h00) strays++;
        end
        check("rst_silent", strays, 0);
        $display("txn reset mid-fetch: strays=%0d", strays);

        check("done0_count", d0_cnt, 1);
        check("done1_never", d1_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
